imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the CPU instruction memory: the core fetches from imem, and this block fills it at boot.
- Consumes a byte stream from the UART receiver on a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them sequentially into imem from address 0.
- Holds the core in reset until the program image is complete, then releases it. Sits between uart_rx and cpu_wrap in the top level.

Parameters:
- ADDR_W, 10, imem word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rstn  out  1  reset to core, active-low, registered.
- loading  out  1  loader in HDR or DATA state.
- done  out  1  image fully written; sticky until rstn.
- err  out  1  header word count exceeds capacity; sticky until rstn.

Behaviour:
- Single clock; reset is synchronous and active-low on rstn, sampled at posedge clk.
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rstn=0, loading=0, done=0, err=0. Internal state returns to HDR, byte index to 0, word counter to 0.
- Reset asserted mid-load aborts the load. The partial image is left in imem and the next load overwrites it.
- Transfer: a byte is accepted in a cycle iff rx_valid && rx_ready. rx_valid is level; no byte is lost or duplicated.
- Byte order: byte k of a word goes to bits [8k+7:8k], k=0..3, first byte in the LSBs.
- State HDR (entered the cycle after reset release; rx_ready=1, loading=1):
  - Collect 4 bytes into the 32-bit count N.
  - On the 4th accepted byte, choose the next state:
    - N==0 -> DONE.
    - N>2**ADDR_W -> ERR.
    - Otherwise -> DATA, with the word counter at 0.
- State DATA (rx_ready=1, loading=1):
  - Collect 4 bytes per word.
  - The cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_addr = word counter, imem_wdata = assembled word. The word counter then increments.
  - Write latency is 1 cycle from the accepting edge.
  - Bytes of the next word may be accepted during the write cycle, so back-to-back bytes sustain 1 word per 4 cycles.
  - After the write of word N-1 -> DONE.
- State DONE:
  - rx_ready=0, loading=0, done=1.
  - cpu_rstn=1 starting the cycle after the last imem_we, or 1 cycle after the header when N==0.
  - Further rx bytes are ignored (not accepted) and stay absorbed by uart_rx.
- State ERR: rx_ready=0, loading=0, err=1, cpu_rstn stays 0, done stays 0.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Wrap-around: N==2**ADDR_W is legal and the last address is all ones. The word counter is ADDR_W+1 bits wide so it never wraps before the compare.
- rx_valid gaps of any length inside a word or header are allowed; partial bytes are retained.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef loader_state_t (HDR, DATA, DONE, ERR).
  - Constant WORD_BYTES=4.
  - Constant LOADER_ADDR_W default.
- One natural sub-module, byte_to_word: an accumulator with a 2-bit index.
  - Inputs: byte, strobe.
  - Outputs: word, word_valid (1-cycle pulse).
  - Reused for both header and data words.
- The FSM lives in imem_loader.

Test Plan:
- Reset/idle: rstn=0 for 3 cycles, then 1 with no rx_valid -> rx_ready=1 from the 2nd cycle after release. All other outputs remain at reset values.
- Basic load:
  - Stimulus: header 02 00 00 00, then bytes 13 05 10 00 | 93 05 20 00, back-to-back.
  - Required:
    - Write addr 0, data 0x00100513.
    - Write addr 1, data 0x00200593.
    - Each imem_we is a single-cycle pulse exactly 1 cycle after its 4th byte.
    - cpu_rstn and done rise the cycle after the 2nd write.
    - rx_ready falls at the same time.
- Gapped stream: same image with rx_valid low for 0..5 random cycles between bytes -> identical writes and data, no extra imem_we.
- Empty image: header 00 00 00 00 -> no imem_we; done=1 and cpu_rstn=1 the cycle after the 4th header byte.
- Overflow (ADDR_W=2): header 05 00 00 00 -> err=1, rx_ready=0, cpu_rstn=0 permanently, no writes.
- Full capacity, plus reset mid-load (ADDR_W=2):
  - Header 04 00 00 00 plus 4 words -> writes to addrs 0..3, done=1.
  - Second run: rstn pulsed low after 6 data bytes -> outputs return to reset values on the next edge.
  - A fresh 1-word image then writes addr 0 correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants.
// Holds the boot loader state encoding and the widths used by the loader
// and its byte-to-word accumulator.
package cpu_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned LOADER_ADDR_W = 10;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word accumulator.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   data, strobe  : incoming byte and its accept strobe
//   word_c        : assembled word (valid together with word_valid_c)
//   word_valid_c  : single-cycle pulse on the strobe carrying the last byte
// The last byte is bypassed straight into word_c so the consumer can act on
// the same edge that accepts it.
module byte_to_word
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [BYTE_W-1:0] data,
    input  logic              strobe,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam int unsigned IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b2;

    // Byte index and the three held low bytes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx <= '0;
            b0  <= '0;
            b1  <= '0;
            b2  <= '0;
        end else if (strobe) begin
            idx <= idx + 1'b1;
            case (idx)
                IDX_W'(0): b0 <= data;
                IDX_W'(1): b1 <= data;
                IDX_W'(2): b2 <= data;
                default:   ;
            endcase
        end
    end

    assign word_c       = {data, b2, b1, b0};
    assign word_valid_c = strobe && (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader that fills the instruction memory from the UART byte stream.
// Stream format: 32-bit little-endian word count N, then N little-endian
// words written to imem addresses 0..N-1. The core is held in reset until
// the image is complete.
// Ports:
//   clk, rstn                  : clock, synchronous active-low reset
//   rx_data, rx_valid, rx_ready: byte stream from uart_rx (valid/ready)
//   imem_we, imem_addr, imem_wdata : imem write port, one pulse per word
//   cpu_rstn                   : active-low reset to the core
//   loading, done, err         : status (done/err sticky until rstn)
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rstn,
    output logic              loading,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-capacity count never wraps before the compare
    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    loader_state_t     state;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  n_words;
    logic              accept_c;
    logic [WORD_W-1:0] word_c;
    logic              word_valid_c;

    assign accept_c = rx_valid && rx_ready;

    byte_to_word u_b2w (
        .clk          (clk),
        .rstn         (rstn),
        .data         (rx_data),
        .strobe       (accept_c),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Loader FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= HDR;
            word_cnt   <= '0;
            n_words    <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rstn   <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR: begin
                    rx_ready <= 1'b1;
                    loading  <= 1'b1;
                    if (word_valid_c) begin
                        if (word_c == '0) begin
                            state    <= DONE;
                            rx_ready <= 1'b0;
                            loading  <= 1'b0;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
                        end else if ({1'b0, word_c} > CAPACITY) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            loading  <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state    <= DATA;
                            n_words  <= CNT_W'(word_c);
                            word_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    // Finish once the write of the last word has gone out
                    if (imem_we && (word_cnt == n_words)) begin
                        state    <= DONE;
                        rx_ready <= 1'b0;
                        loading  <= 1'b0;
                        done     <= 1'b1;
                        cpu_rstn <= 1'b1;
                    end else if (word_valid_c) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= word_c;
                        word_cnt   <= word_cnt + 1'b1;
                    end
                end
                DONE: ;
                ERR:  ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2): expected imem writes are queued
// as each word is driven and matched against the write port by a monitor.
module tb_imem_loader;

    localparam int unsigned AW = 2;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn;
    logic          loading;
    logic          done;
    logic          err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    logic prev_we = 1'b0;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .loading    (loading),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("we_pulse_width", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(imem_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
        prev_we <= imem_we;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
        chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_cpu_rstn"},   32'(cpu_rstn),   32'd0);
        chk({tag, "_loading"},    32'(loading),    32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    // Hold reset for 3 cycles; called and returns at a falling edge
    task automatic do_reset(input string tag);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset(tag);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        rstn = 1'b1;
        chk({tag, "_rel_cycle1_rx_ready"}, 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_rel_cycle2_rx_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_rel_cycle2_loading"},  32'(loading),  32'd1);
    endtask

    // Present one byte after an optional idle gap; returns at the falling
    // edge right after the accepting rising edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = w[8*k +: 8];
            send_byte(b, (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0)));
        end
    endtask

    task automatic send_data(input int addr, input logic [31:0] w, input int gapmax);
        exp_q.push_back('{32'(addr), w});
        send_word(w, gapmax);
        chk("we_latency", 32'(imem_we), 32'd1);
    endtask

    // Called right after the last data byte: done/cpu_rstn follow the write
    task automatic finish_load(input string tag);
        rx_valid = 1'b0;
        chk({tag, "_done_in_wr_cycle"},     32'(done),     32'd0);
        chk({tag, "_cpu_rstn_in_wr_cycle"}, 32'(cpu_rstn), 32'd0);
        chk({tag, "_rx_ready_in_wr_cycle"}, 32'(rx_ready), 32'd1);
        @(negedge clk);
        chk({tag, "_done"},     32'(done),     32'd1);
        chk({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd1);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_loading"},  32'(loading),  32'd0);
        chk({tag, "_imem_we"},  32'(imem_we),  32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_q_empty"},  32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        @(negedge clk);

        // Reset and idle
        do_reset("idle");
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd1);
        chk("idle_imem_we",  32'(imem_we),  32'd0);
        chk("idle_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("idle_done",     32'(done),     32'd0);
        chk("idle_err",      32'(err),      32'd0);

        // Basic back-to-back load of two words
        send_word(32'd2, 0);
        send_data(0, 32'h0010_0513, 0);
        send_data(1, 32'h0020_0593, 0);
        finish_load("basic");
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("done_ignores_rx_ready", 32'(rx_ready), 32'd0);
        chk("done_sticky",           32'(done),     32'd1);
        rx_valid = 1'b0;

        // Same image with random gaps between bytes
        do_reset("gap");
        send_word(32'd2, 5);
        send_data(0, 32'h0010_0513, 5);
        send_data(1, 32'h0020_0593, 5);
        finish_load("gapped");

        // Empty image
        do_reset("empty");
        send_word(32'd0, 0);
        rx_valid = 1'b0;
        chk("empty_done",     32'(done),     32'd1);
        chk("empty_cpu_rstn", 32'(cpu_rstn), 32'd1);
        chk("empty_rx_ready", 32'(rx_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("empty_done_hold", 32'(done), 32'd1);
        chk("empty_err",       32'(err),  32'd0);

        // Overflow: 5 words into a 4-word memory
        do_reset("ovf");
        send_word(32'd5, 0);
        chk("ovf_err",      32'(err),      32'd1);
        chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
        chk("ovf_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("ovf_done",     32'(done),     32'd0);
        chk("ovf_loading",  32'(loading),  32'd0);
        rx_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("ovf_err_hold",      32'(err),      32'd1);
        chk("ovf_cpu_rstn_hold", 32'(cpu_rstn), 32'd0);
        chk("ovf_rx_ready_hold", 32'(rx_ready), 32'd0);
        chk("ovf_done_hold",     32'(done),     32'd0);
        rx_valid = 1'b0;

        // Full capacity, last address all ones
        do_reset("full");
        send_word(32'd4, 0);
        send_data(0, 32'h1111_0001, 0);
        send_data(1, 32'h2222_0002, 0);
        send_data(2, 32'h3333_0003, 0);
        send_data(3, 32'hA5A5_5A5A, 0);
        finish_load("full");

        // Reset pulse in the middle of a load, then a fresh one-word image
        do_reset("mid");
        send_word(32'd4, 0);
        send_data(0, 32'hCAFE_F00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        rstn = 1'b1;
        @(negedge clk);
        send_word(32'd1, 0);
        send_data(0, 32'hDEAD_BEEF, 0);
        finish_load("reload");

        repeat (4) @(negedge clk);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
